// File: rtl/kbd_pkg.sv
// Shared constants and state types for the PS/2 keyboard responder.
// Optional parity checking is enabled with the KBD_PARITY_CHECK_EN macro.
package kbd_pkg;

    localparam logic KBD_REG_DATA   = 1'b0;
    localparam logic KBD_REG_STATUS = 1'b1;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVF       = 1;
    localparam int ST_CNT_LSB   = 2;
    localparam int ST_PERR_LSB  = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic {RD_IDLE, RD_DONE} rd_state_e;

    // Odd parity: data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM and timeout.
// Parity is checked only when KBD_PARITY_CHECK_EN is defined.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       perr_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          data_s1_q, data_s2_q;
    logic          fall;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
`ifdef KBD_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
        par_d     = par_q;
`endif

        // A stalled partial frame is abandoned; any falling edge restarts the count.
        if (state_q == RX_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            state_d  = RX_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                    par_d = data_s2_q;
`endif
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_s2_q) begin
`ifdef KBD_PARITY_CHECK_EN
                        if (odd_parity_ok(shift_q, par_q)) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
`else
                        byte_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            to_cnt_q   <= '0;
            byte_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data;
            data_s2_q  <= data_s1_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign perr_pulse = perr_q;

endmodule

// File: rtl/kbd_responder.sv
// Memory-mapped PS/2 keyboard responder: scan-code FIFO, status word and read stall handshake.
// KBD_PARITY_CHECK_EN enables parity checking and the PERR counter.
module kbd_responder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_sel,
    input  logic        kbd_rd,
    input  logic        kbd_addr,
    output logic [31:0] kbd_rdata,
    output logic        kbd_stall,
    output logic        kbd_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        perr_pulse;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  perr_q, perr_d;
    logic [31:0] rdata_q, rdata_d;
    rd_state_e   rd_state_q, rd_state_d;

    logic [AW:0] count;
    logic [6:0]  cnt_ext;
    logic [5:0]  cnt_field;
    logic        empty, full;
    logic        req, take, pop, push_ok, ovf_set, st_rd;
    logic [31:0] status_word;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .perr_pulse (perr_pulse)
    );

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cnt_ext = 7'(count);
    // A 64-deep FIFO can hold 64 entries; the 6-bit field saturates rather than wrapping to 0.
    assign cnt_field = cnt_ext[6] ? 6'h3f : cnt_ext[5:0];

    assign req     = kbd_sel & kbd_rd;
    assign take    = req & (rd_state_q == RD_IDLE);
    assign pop     = take & (kbd_addr == KBD_REG_DATA) & ~empty;
    assign st_rd   = take & (kbd_addr == KBD_REG_STATUS);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = byte_valid & (~full | pop);
    assign ovf_set = byte_valid & full & ~pop;

    always_comb begin
        status_word = 32'h0;
        status_word[ST_NOT_EMPTY] = ~empty;
        status_word[ST_OVF] = ovf_q;
        status_word[ST_CNT_LSB +: 6] = cnt_field;
        status_word[ST_PERR_LSB +: 8] = perr_q;
    end

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rdata_d    = rdata_q;
        rd_state_d = rd_state_q;

        if (ovf_set)    ovf_d = 1'b1;
        else if (st_rd) ovf_d = 1'b0;
        else            ovf_d = ovf_q;

        if (perr_pulse)  perr_d = st_rd ? 8'd1 : ((perr_q == 8'hff) ? 8'hff : perr_q + 8'd1);
        else if (st_rd)  perr_d = 8'd0;
        else             perr_d = perr_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (req) begin
                    if (kbd_addr == KBD_REG_STATUS) rdata_d = status_word;
                    else if (empty)                 rdata_d = 32'h0;
                    else                            rdata_d = {24'h0, mem_q[rd_ptr_q[AW-1:0]]};
                    rd_state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                if (!req) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 8'd0;
            rdata_q    <= 32'h0;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            rdata_q    <= rdata_d;
            rd_state_q <= rd_state_d;
        end
    end

    assign kbd_rdata = rdata_q;
    assign kbd_stall = take;
    assign kbd_irq   = ~empty;

endmodule

// File: tb/tb_kbd_responder.sv
// Directed bench for kbd_responder: PS/2 frames in, DATA/STATUS reads out.
// Honours KBD_PARITY_CHECK_EN when computing expected status words.
module tb_kbd_responder;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kbd_sel = 1'b0;
    logic        kbd_rd = 1'b0;
    logic        kbd_addr = 1'b0;
    logic [31:0] kbd_rdata;
    logic        kbd_stall;
    logic        kbd_irq;

    int checks = 0;
    int errors = 0;

    kbd_responder #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbd_sel   (kbd_sel),
        .kbd_rd    (kbd_rd),
        .kbd_addr  (kbd_addr),
        .kbd_rdata (kbd_rdata),
        .kbd_stall (kbd_stall),
        .kbd_irq   (kbd_irq)
    );

    always #5 clk = ~clk;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic ps2_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
    endtask

    task automatic do_read(input logic a, output logic [31:0] d, output int stalls);
        @(negedge clk);
        kbd_sel = 1'b1; kbd_rd = 1'b1; kbd_addr = a;
        #1;
        stalls = 0;
        while (kbd_stall && stalls < 8) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        d = kbd_rdata;
        kbd_sel = 1'b0; kbd_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int st;
        apply_reset();
        #1;
        checks++;
        if (kbd_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", kbd_rdata, 32'h0); end
        checks++;
        if (kbd_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", kbd_stall); end
        checks++;
        if (kbd_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", kbd_irq); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        int st;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(((8'h1C >> i) & 8'h1) != 0);
        ps2_bit(1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (kbd_irq !== 1'b0) begin errors++; $display("FAIL latency_early: irq %b want 0 after 3 cycles", kbd_irq); end
        @(posedge clk);
        #1;
        checks++;
        if (kbd_irq !== 1'b1) begin errors++; $display("FAIL latency_4: irq %b want 1 after 4 cycles", kbd_irq); end
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        do_read(1'b0, d, st);
        checks++;
        if (st != 1) begin errors++; $display("FAIL data_stall_cycles: got %0d want 1", st); end
        checks++;
        if (d !== 32'h0000_001C) begin errors++; $display("FAIL data_1c: got %h want %h", d, 32'h1C); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL status_after_pop: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        int st;
        send_frame(8'hF0, 1'b0, 1'b1);
        do_read(1'b1, d, st);
`ifdef KBD_PARITY_CHECK_EN
        checks++;
        if (d !== 32'h0000_0100) begin errors++; $display("FAIL perr_status: got %h want %h", d, 32'h100); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL perr_cleared: got %h want %h", d, 32'h0); end
`else
        checks++;
        if (d !== 32'h0000_0005) begin errors++; $display("FAIL noparity_status: got %h want %h", d, 32'h5); end
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0000_00F0) begin errors++; $display("FAIL noparity_data: got %h want %h", d, 32'hF0); end
`endif
        #1;
        checks++;
        if (kbd_irq !== 1'b0) begin errors++; $display("FAIL parity_irq: got %b want 0", kbd_irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int st;
        for (int i = 1; i <= 17; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
        do_read(1'b1, d, st);
        // count 16 in [7:2], OVF, NOT_EMPTY
        checks++;
        if (d !== 32'h0000_0043) begin errors++; $display("FAIL ovf_status: got %h want %h", d, 32'h43); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0000_0041) begin errors++; $display("FAIL ovf_cleared: got %h want %h", d, 32'h41); end
        for (int i = 1; i <= 16; i++) begin
            do_read(1'b0, d, st);
            checks++;
            if (d !== 32'(i)) begin errors++; $display("FAIL fifo_order[%0d]: got %h want %h", i, d, 32'(i)); end
        end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL drained_status: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int st;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 10) @(negedge clk);
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL timeout_nopush: got %h want %h", d, 32'h0); end
        send_frame(8'h5A, 1'b1, 1'b1);
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0000_005A) begin errors++; $display("FAIL timeout_recover: got %h want %h", d, 32'h5A); end
    endtask

    task automatic test_empty_read();
        logic [31:0] d;
        int st;
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL empty_data: got %h want %h", d, 32'h0); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL empty_status: got %h want %h", d, 32'h0); end
        send_frame(8'h33, 1'b1, 1'b1);
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0000_0033) begin errors++; $display("FAIL empty_then_data: got %h want %h", d, 32'h33); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int st;
        send_frame(8'h21, odd_par(8'h21), 1'b1);
        send_frame(8'h22, odd_par(8'h22), 1'b1);
        @(negedge clk);
        kbd_sel = 1'b1; kbd_rd = 1'b1; kbd_addr = 1'b0;
        repeat (3) @(negedge clk);
        d = kbd_rdata;
        kbd_sel = 1'b0; kbd_rd = 1'b0;
        checks++;
        if (d !== 32'h0000_0021) begin errors++; $display("FAIL hold_data: got %h want %h", d, 32'h21); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0000_0005) begin errors++; $display("FAIL hold_one_pop: got %h want %h", d, 32'h5); end
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0000_0022) begin errors++; $display("FAIL hold_next: got %h want %h", d, 32'h22); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int st;
        send_frame(8'h44, odd_par(8'h44), 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(((8'h55 >> i) & 8'h1) != 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (kbd_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", kbd_irq); end
        do_read(1'b1, d, st);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want %h", d, 32'h0); end
        send_frame(8'h12, odd_par(8'h12), 1'b1);
        do_read(1'b0, d, st);
        checks++;
        if (d !== 32'h0000_0012) begin errors++; $display("FAIL midreset_recover: got %h want %h", d, 32'h12); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_overflow();
        test_timeout();
        test_empty_read();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
